guess_sequencer: RTL and testbench

GUESS_SEQUENCER -- requirements
Module: guess_sequencer

---
 rtl/guess_sequencer.sv | 120 ++++++++++++
 tb/tb_guess_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/guess_sequencer.sv
// guess_sequencer: edits a 4-slot colour guess with cursor buttons and stores submitted guesses in a browsable history buffer.
module guess_sequencer #(
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_color,
  input  logic                          btn_submit,
  input  logic                          btn_history,
  output logic                          blink_enable,
  output logic [1:0]                    blink_led,
  output logic [2:0]                    guess_rgb0,
  output logic [2:0]                    guess_rgb1,
  output logic [2:0]                    guess_rgb2,
  output logic [2:0]                    guess_rgb3,
  output logic [2:0]                    history_rgb0,
  output logic [2:0]                    history_rgb1,
  output logic [2:0]                    history_rgb2,
  output logic [2:0]                    history_rgb3,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
  output logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic                          locked
);
  localparam int IW = $clog2(HIST_DEPTH);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {EDIT, HISTORY, LOCKED} state_t;
  state_t          r_state, w_state;
  logic [3:0][2:0] r_slot, w_slot;
  logic [1:0]      r_cursor, w_cursor;
  logic [CW-1:0]   r_count, w_count;
  logic [IW-1:0]   r_idx, w_idx;
  logic [11:0]     r_mem [HIST_DEPTH];
  logic [11:0]     r_hist;
  logic            r_blink, r_locked;
  logic            w_wr;
  logic            w_valid;
  logic            w_empty;
  logic [IW-1:0]   w_last, w_dec, w_inc;
  assign w_valid = (r_slot[0] != 3'd0) && (r_slot[1] != 3'd0) && (r_slot[2] != 3'd0) && (r_slot[3] != 3'd0);
  assign w_empty = (r_count == '0);
  assign w_last  = IW'(r_count - CW'(1));
  // Browsing wraps inside the stored range; an empty buffer pins the index at 0.
  assign w_dec   = w_empty ? '0 : (r_idx == '0) ? w_last : r_idx - IW'(1);
  assign w_inc   = w_empty ? '0 : (r_idx == w_last) ? '0 : r_idx + IW'(1);
  always_comb begin
    w_state  = r_state;
    w_slot   = r_slot;
    w_cursor = r_cursor;
    w_count  = r_count;
    w_idx    = r_idx;
    w_wr     = 1'b0;
    if (r_state == EDIT) begin
      if (btn_submit) begin
        if (w_valid) begin
          w_wr     = 1'b1;
          w_count  = r_count + CW'(1);
          w_slot   = '0;
          w_cursor = 2'd0;
          w_idx    = r_count[IW-1:0];
          w_state  = (r_count == CW'(HIST_DEPTH - 1)) ? LOCKED : EDIT;
        end
      end else if (btn_history) begin
        w_state = HISTORY;
        w_idx   = w_empty ? '0 : w_last;
      end else if (btn_color) begin
        w_slot[r_cursor] = r_slot[r_cursor] + 3'd1;
      end else if (btn_left) begin
        w_cursor = r_cursor - 2'd1;
      end else if (btn_right) begin
        w_cursor = r_cursor + 2'd1;
      end
    end else if (!btn_submit) begin
      if (btn_history) begin
        w_state = (r_state == HISTORY) ? EDIT : r_state;
      end else if (!btn_color) begin
        w_idx = btn_left ? w_dec : btn_right ? w_inc : r_idx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= EDIT;
      r_slot   <= '0;
      r_cursor <= 2'd0;
      r_count  <= '0;
      r_idx    <= '0;
      r_hist   <= '0;
      r_blink  <= 1'b1;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_slot   <= w_slot;
      r_cursor <= w_cursor;
      r_count  <= w_count;
      r_idx    <= w_idx;
      r_hist   <= w_empty ? 12'd0 : r_mem[r_idx];
      r_blink  <= (w_state == EDIT);
      r_locked <= (w_state == LOCKED);
    end
  end
  // Entries are never cleared; an empty count masks stale contents after reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr) r_mem[r_count[IW-1:0]] <= r_slot;
  end
  assign blink_enable = r_blink;
  assign locked       = r_locked;
  assign blink_led    = r_cursor;
  assign guess_rgb0   = r_slot[0];
  assign guess_rgb1   = r_slot[1];
  assign guess_rgb2   = r_slot[2];
  assign guess_rgb3   = r_slot[3];
  assign history_rgb0 = r_hist[2:0];
  assign history_rgb1 = r_hist[5:3];
  assign history_rgb2 = r_hist[8:6];
  assign history_rgb3 = r_hist[11:9];
  assign hist_count   = r_count;
  assign hist_idx     = r_idx;
endmodule

// File: tb/tb_guess_sequencer.sv
// tb_guess_sequencer: directed vector table plus hand-written sequences for guess_sequencer.
module tb_guess_sequencer;
  localparam logic [4:0] N = 5'b00000, R = 5'b00001, L = 5'b00010, C = 5'b00100, H = 5'b01000, S = 5'b10000;
  typedef struct {
    logic        rst_n;
    logic [4:0]  btn;
    logic [34:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] b = '0;
  logic       blink_enable, locked;
  logic [1:0] blink_led;
  logic [2:0] g0, g1, g2, g3, h0, h1, h2, h3;
  logic [3:0] hist_count;
  logic [2:0] hist_idx;
  int total = 0;
  int bad = 0;
  vec_t q[$];
  logic       eb, ek;
  logic [1:0] el;
  logic [2:0] eg [4];
  logic [11:0] eh;
  logic [3:0] ec;
  logic [2:0] ei;
  guess_sequencer #(.HIST_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(b[1]), .btn_right(b[0]), .btn_color(b[2]), .btn_submit(b[4]), .btn_history(b[3]),
    .blink_enable(blink_enable), .blink_led(blink_led),
    .guess_rgb0(g0), .guess_rgb1(g1), .guess_rgb2(g2), .guess_rgb3(g3),
    .history_rgb0(h0), .history_rgb1(h1), .history_rgb2(h2), .history_rgb3(h3),
    .hist_count(hist_count), .hist_idx(hist_idx), .locked(locked)
  );
  always #5 clk = ~clk;
  function automatic logic [34:0] outs();
    return {blink_enable, blink_led, g3, g2, g1, g0, h3, h2, h1, h0, hist_count, hist_idx, locked};
  endfunction
  function automatic logic [11:0] entry(int n);
    return {3'd1, 3'd1, 3'd1, 3'(n % 7 + 1)};
  endfunction
  function automatic void add(logic rst, logic [4:0] btn);
    vec_t v;
    v.rst_n = rst;
    v.btn   = btn;
    v.exp   = {eb, el, eg[3], eg[2], eg[1], eg[0], eh, ec, ei, ek};
    q.push_back(v);
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(logic rst, logic [4:0] btn);
    @(negedge clk);
    rst_n = rst;
    b = btn;
    @(posedge clk);
    #1;
    b = N;
  endtask
  task automatic press(logic [4:0] btn);
    drive(1'b1, btn);
  endtask
  task automatic submit_entry(int n);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < (j == 0 ? n % 7 + 1 : 1); k++) press(C);
      press(R);
    end
    press(S);
  endtask
  initial begin
    eb = 1; el = 0; eh = 0; ec = 0; ei = 0; ek = 0;
    for (int j = 0; j < 4; j++) eg[j] = 0;
    add(0, N);
    add(0, R);
    for (int k = 1; k <= 5; k++) begin el = 2'(k % 4); add(1, R); end
    el = 0; add(1, L);
    el = 3; add(1, L);
    el = 2; add(1, L);
    for (int k = 1; k <= 8; k++) begin eg[2] = 3'(k % 8); add(1, C); end
    el = 1; add(1, L);
    el = 0; add(1, L);
    eg[0] = 1; add(1, C);
    el = 1; add(1, R);
    eg[1] = 1; add(1, C);
    eg[1] = 2; add(1, C);
    el = 2; add(1, R);
    for (int k = 1; k <= 3; k++) begin eg[2] = 3'(k); add(1, C); end
    el = 3; add(1, R);
    add(1, S);
    for (int k = 1; k <= 4; k++) begin eg[3] = 3'(k); add(1, C); end
    for (int j = 0; j < 4; j++) eg[j] = 0;
    el = 0; ec = 1; ei = 0; add(1, S | C);
    eb = 0; eh = 12'h8D1; add(1, H);
    add(1, R);
    add(1, C);
    add(1, S);
    eb = 1; add(1, H);
    eb = 0; add(1, H | C);
    eb = 1; add(1, H);
    el = 3; add(1, L | R);
    foreach (q[i]) begin
      drive(q[i].rst_n, q[i].btn);
      check($sformatf("vec%0d", i), 64'(outs()), 64'(q[i].exp));
    end
    press(R);
    check("cursor_wrap", 64'(blink_led), 64'd0);
    submit_entry(1);
    submit_entry(2);
    check("count3", 64'(hist_count), 64'd3);
    press(H);
    press(N);
    check("hist_idx2", {blink_enable, hist_idx, h3, h2, h1, h0}, {1'b0, 3'd2, entry(2)});
    press(L);
    press(N);
    check("hist_idx1", {hist_idx, h3, h2, h1, h0}, {3'd1, entry(1)});
    drive(1'b0, C);
    check("reset_in_history", 64'(outs()), {1'b1, 2'd0, 12'd0, 12'd0, 4'd0, 3'd0, 1'b0});
    for (int n = 0; n < 8; n++) begin
      submit_entry(n);
      if (n == 6) check("not_locked_at_7", {locked, blink_enable, hist_count}, {1'b0, 1'b1, 4'd7});
    end
    check("locked_full", {locked, blink_enable, hist_count, hist_idx, g3, g2, g1, g0}, {1'b1, 1'b0, 4'd8, 3'd7, 12'd0});
    press(N);
    check("locked_hist7", {h3, h2, h1, h0}, entry(7));
    press(R);
    check("locked_right_wrap", 64'(hist_idx), 64'd0);
    press(L);
    press(L);
    press(N);
    check("locked_hist6", {hist_idx, h3, h2, h1, h0}, {3'd6, entry(6)});
    press(H);
    press(S);
    press(C);
    check("locked_ignore", {locked, blink_enable, hist_count, hist_idx, g3, g2, g1, g0}, {1'b1, 1'b0, 4'd8, 3'd6, 12'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
